// File: rtl/taylor_pkg.sv
// Shared types and constants for the folded Taylor-series sequencer.
package taylor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] ONE_Q31  = 32'h7FFF_FFFF;
    localparam logic [31:0] ZERO_Q31 = 32'h0000_0000;

    localparam int DEF_N_TERMS = 8;
    localparam int DEF_ITER_W  = 3;

endpackage

// File: rtl/taylor_seq_ctrl.sv
// Folded Taylor-series sequencer: drives one external combinational slice for N_TERMS cycles.
// Optional macro TAYLOR_EARLY_EXIT_EN: stop once the running power reaches zero and expose iter_count.
module taylor_seq_ctrl
    import taylor_pkg::*;
#(
    parameter int          N_TERMS  = DEF_N_TERMS,
    parameter int          ITER_W   = DEF_ITER_W,
    parameter logic [31:0] NUM_INIT = ONE_Q31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_sum,
    output logic              out_overflow,
    output logic              busy,
    output logic [31:0]       slice_x,
    output logic [31:0]       slice_num,
    output logic [31:0]       slice_sum,
    output logic [ITER_W-1:0] slice_i,
    output logic              slice_ovf,
    input  logic [31:0]       slice_out_num,
    input  logic [31:0]       slice_out_sum,
    input  logic              slice_out_ovf
`ifdef TAYLOR_EARLY_EXIT_EN
    ,
    output logic [ITER_W:0]   iter_count
`endif
);

    // One extra bit so N_TERMS == 2**ITER_W does not wrap the counter.
    localparam logic [ITER_W:0] LAST = (ITER_W+1)'(N_TERMS - 1);

    state_t          state, state_nxt;
    logic [31:0]     x_r, num_r, sum_r;
    logic            ovf_r;
    logic [ITER_W:0] cnt;
    logic            last_iter;

`ifdef TAYLOR_EARLY_EXIT_EN
    assign last_iter = (cnt == LAST) || (slice_out_num == ZERO_Q31);
`else
    assign last_iter = (cnt == LAST);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = ITER;
            ITER:    if (last_iter) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            x_r   <= ZERO_Q31;
            num_r <= ZERO_Q31;
            sum_r <= ZERO_Q31;
            ovf_r <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid) begin
                    x_r   <= in_x;
                    num_r <= NUM_INIT;
                    sum_r <= ZERO_Q31;
                    ovf_r <= 1'b0;
                    cnt   <= '0;
                end
                ITER: begin
                    num_r <= slice_out_num;
                    sum_r <= slice_out_sum;
                    ovf_r <= slice_out_ovf;
                    cnt   <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = (state == IDLE);
    assign busy         = (state == ITER) || (state == DONE);
    assign out_valid    = (state == DONE);
    assign out_sum      = sum_r;
    assign out_overflow = ovf_r;

    assign slice_x   = x_r;
    assign slice_num = num_r;
    assign slice_sum = sum_r;
    assign slice_i   = cnt[ITER_W-1:0];
    assign slice_ovf = ovf_r;

`ifdef TAYLOR_EARLY_EXIT_EN
    assign iter_count = cnt;
`endif

endmodule

// File: tb/tb_taylor_seq_ctrl.sv
// Directed bench for taylor_seq_ctrl paired with a behavioural single-term slice.
// Handles TAYLOR_EARLY_EXIT_EN builds by deriving the expected iteration count.
module tb_taylor_seq_ctrl;

    localparam int N_TERMS = 8;
    localparam int ITER_W  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_x;
    logic        out_valid, out_ready;
    logic [31:0] out_sum;
    logic        out_overflow, busy;
    logic [31:0] slice_x, slice_num, slice_sum;
    logic [2:0]  slice_i;
    logic        slice_ovf;
    logic [31:0] slice_out_num, slice_out_sum;
    logic        slice_out_ovf;
`ifdef TAYLOR_EARLY_EXIT_EN
    logic [3:0]  iter_count;
`endif

    logic [31:0] coef [N_TERMS];
    logic [64:0] slice_res;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    taylor_seq_ctrl #(
        .N_TERMS (N_TERMS),
        .ITER_W  (ITER_W),
        .NUM_INIT(32'h7FFF_FFFF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_overflow (out_overflow),
        .busy         (busy),
        .slice_x      (slice_x),
        .slice_num    (slice_num),
        .slice_sum    (slice_sum),
        .slice_i      (slice_i),
        .slice_ovf    (slice_ovf),
        .slice_out_num(slice_out_num),
        .slice_out_sum(slice_out_sum),
        .slice_out_ovf(slice_out_ovf)
`ifdef TAYLOR_EARLY_EXIT_EN
        ,
        .iter_count   (iter_count)
`endif
    );

    // One Taylor term in Q1.31: num' = num*x, sum' = sum + c*num', sticky signed-add overflow.
    function automatic logic [64:0] taylor_slice_model(input logic [31:0] x, input logic [31:0] num,
                                                       input logic [31:0] sum, input logic [31:0] c,
                                                       input logic ovf);
        logic signed [63:0] a, b, p;
        logic [31:0] nn, term, ns;
        logic        o;
        a  = {{32{num[31]}}, num};
        b  = {{32{x[31]}}, x};
        p  = a * b;
        nn = p[62:31];
        a  = {{32{c[31]}}, c};
        b  = {{32{nn[31]}}, nn};
        p  = a * b;
        term = p[62:31];
        ns = sum + term;
        o  = (sum[31] == term[31]) && (ns[31] != sum[31]);
        return {nn, ns, ovf | o};
    endfunction

    always_comb slice_res = taylor_slice_model(slice_x, slice_num, slice_sum, coef[slice_i], slice_ovf);
    assign slice_out_num = slice_res[64:33];
    assign slice_out_sum = slice_res[32:1];
    assign slice_out_ovf = slice_res[0];

    // Reference evaluation: iterate the slice from 1.0 and note how many terms run.
    task automatic run_model(input logic [31:0] x, output logic [31:0] s, output logic o, output int iters);
        logic [31:0] n;
        logic [64:0] r;
        n = 32'h7FFF_FFFF; s = '0; o = 1'b0; iters = 0;
        for (int k = 0; k < N_TERMS; k++) begin
            r = taylor_slice_model(x, n, s, coef[k], o);
            n = r[64:33]; s = r[32:1]; o = r[0];
            iters = k + 1;
`ifdef TAYLOR_EARLY_EXIT_EN
            if (n == 32'h0) break;
`endif
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_coef(input logic [31:0] c);
        for (int k = 0; k < N_TERMS; k++) coef[k] = c;
    endtask

    task automatic start(input logic [31:0] x);
        in_valid = 1'b1;
        in_x     = x;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts accept-relative edges until out_valid; optionally checks the term index each cycle.
    task automatic wait_done(input bit chk_idx, output int edges);
        edges = 0;
        while (!out_valid && edges < 50) begin
            if (chk_idx) chk("slice_i", 64'(slice_i), 64'(edges[2:0]));
            @(negedge clk);
            edges++;
        end
        if (!out_valid) chk("done_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic handoff;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("handoff_out_valid", 64'(out_valid), 64'd0);
        chk("handoff_in_ready", 64'(in_ready), 64'd1);
    endtask

    logic [31:0] m_sum, held_sum;
    logic        m_ovf, held_ovf;
    int          m_iters, edges;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
        set_coef(32'h4000_0000);
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_ovf", 64'(out_overflow), 64'd0);
        chk("rst_slice_num", 64'(slice_num), 64'd0);
        chk("rst_slice_x", 64'(slice_x), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Abort mid-evaluation
        start(32'h4000_0000);
        @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_slice_sum", 64'(slice_sum), 64'd0);
        chk("abort_slice_num", 64'(slice_num), 64'd0);

        // x = 0: all terms zero
        start(32'h0);
        run_model(32'h0, m_sum, m_ovf, m_iters);
        wait_done(1'b1, edges);
`ifdef TAYLOR_EARLY_EXIT_EN
        chk("x0_latency", 64'(edges), 64'd1);
        chk("x0_iter_count", 64'(iter_count), 64'd1);
`else
        chk("x0_latency", 64'(edges), 64'd8);
`endif
        chk("x0_sum", 64'(out_sum), 64'd0);
        chk("x0_ovf", 64'(out_overflow), 64'd0);
        handoff();

        // x = 0.5, c = 0.5: sum ~ 0.5*(1 - 2^-8)
        start(32'h4000_0000);
        run_model(32'h4000_0000, m_sum, m_ovf, m_iters);
        wait_done(1'b0, edges);
        chk("half_latency", 64'(edges), 64'(m_iters));
        chk("half_sum", 64'(out_sum), 64'(m_sum));
        chk("half_sum_range", 64'(out_sum >= 32'h3FBF_0000 && out_sum <= 32'h3FC0_0000), 64'd1);
        chk("half_ovf", 64'(out_overflow), 64'd0);
        handoff();

        // x ~ 1.0, c ~ 1.0: overflow on the second term, sticky to the end
        set_coef(32'h7FFF_FFFF);
        start(32'h7FFF_FFFF);
        run_model(32'h7FFF_FFFF, m_sum, m_ovf, m_iters);
        chk("one_ovf_it1", 64'(slice_ovf), 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk("one_ovf_it2", 64'(slice_ovf), 64'd1);
        wait_done(1'b0, edges);
        chk("one_sum", 64'(out_sum), 64'(m_sum));
        chk("one_ovf", 64'(out_overflow), 64'd1);

        // Backpressure while DONE; in_valid must be ignored
        held_sum = out_sum;
        held_ovf = out_overflow;
        in_valid = 1'b1;
        in_x     = 32'h0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_sum", 64'(out_sum), 64'(held_sum));
            chk("bp_out_ovf", 64'(out_overflow), 64'(held_ovf));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_handoff_in_ready", 64'(in_ready), 64'd1);
        chk("bp_handoff_busy", 64'(busy), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_accept_busy", 64'(busy), 64'd1);
        chk("bp_accept_x", 64'(slice_x), 64'd0);
        run_model(32'h0, m_sum, m_ovf, m_iters);
        wait_done(1'b0, edges);
        chk("bp_next_latency", 64'(edges), 64'(m_iters));
        chk("bp_next_sum", 64'(out_sum), 64'd0);
        chk("bp_next_ovf", 64'(out_overflow), 64'd0);
        handoff();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
